systolic_mac_lanes: RTL and testbench

//  Parametrised multi-lane signed multiply/accumulate unit for the systolic datapath.

---
 rtl/systolic_mac_lanes.sv | 203 ++++++++++++++++++++
 tb/tb_systolic_mac_lanes.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_lanes.sv
// Multi-lane signed multiply/accumulate unit: operand retiming pipeline, product register,
// then a per-lane product/accumulate output stage with optional saturation and sticky overflow.
module systolic_mac_lanes #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PSUM_W = 20,
    parameter int unsigned PIPE   = 4,
    parameter int unsigned SAT_EN = 1
) (
    input  logic                      s_clk,
    input  logic                      s_rst,
    input  logic                      in_valid,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    input  logic                      in_mode,
    input  logic                      in_first,
    input  logic                      in_last,
    output logic [LANES*PSUM_W-1:0]   out_data,
    output logic                      out_valid,
    output logic [LANES-1:0]          out_ovf
);

    localparam int unsigned OP_W   = LANES * DATA_W;
    localparam int unsigned RES_W  = LANES * PSUM_W;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = PSUM_W + 1;
    localparam logic [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Operand retiming pipeline
    // ------------------------------------------------------------------
    logic [PIPE-1:0] vld_q,   vld_d;
    logic [PIPE-1:0] mode_q,  mode_d;
    logic [PIPE-1:0] first_q, first_d;
    logic [PIPE-1:0] last_q,  last_d;
    logic [OP_W-1:0] a_q [PIPE];
    logic [OP_W-1:0] a_d [PIPE];
    logic [OP_W-1:0] b_q [PIPE];
    logic [OP_W-1:0] b_d [PIPE];

    always_comb begin : pipe_shift
        vld_d      = vld_q;
        mode_d     = mode_q;
        first_d    = first_q;
        last_d     = last_q;
        a_d        = a_q;
        b_d        = b_q;
        vld_d[0]   = in_valid;
        mode_d[0]  = in_mode;
        first_d[0] = in_first;
        last_d[0]  = in_last;
        a_d[0]     = in_a;
        b_d[0]     = in_b;
        for (int unsigned i = 1; i < PIPE; i++) begin
            vld_d[i]   = vld_q[i-1];
            mode_d[i]  = mode_q[i-1];
            first_d[i] = first_q[i-1];
            last_d[i]  = last_q[i-1];
            a_d[i]     = a_q[i-1];
            b_d[i]     = b_q[i-1];
        end
    end

    always_ff @(posedge s_clk) begin : pipe_vld_reg
        if (s_rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload flops carry no reset: they are only consumed alongside a set valid bit.
    always_ff @(posedge s_clk) begin : pipe_data_reg
        mode_q  <= mode_d;
        first_q <= first_d;
        last_q  <= last_d;
        a_q     <= a_d;
        b_q     <= b_d;
    end

    // ------------------------------------------------------------------
    // Product register: lane multiply at the last retiming stage
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic pv_q, pv_d;
    logic pm_q, pm_d;
    logic pf_q, pf_d;
    logic pl_q, pl_d;

    always_comb begin : prod_next
        pv_d = vld_q[PIPE-1];
        pm_d = mode_q[PIPE-1];
        pf_d = first_q[PIPE-1];
        pl_d = last_q[PIPE-1];
        for (int unsigned k = 0; k < LANES; k++) begin
            prod_d[k] = PROD_W'($signed(a_q[PIPE-1][k*DATA_W +: DATA_W]))
                      * PROD_W'($signed(b_q[PIPE-1][k*DATA_W +: DATA_W]));
        end
    end

    always_ff @(posedge s_clk) begin : prod_vld_reg
        if (s_rst) begin
            pv_q <= 1'b0;
        end else begin
            pv_q <= pv_d;
        end
    end

    always_ff @(posedge s_clk) begin : prod_data_reg
        pm_q   <= pm_d;
        pf_q   <= pf_d;
        pl_q   <= pl_d;
        prod_q <= prod_d;
    end

    // ------------------------------------------------------------------
    // Per-lane sum with one guard bit; overflow when the two top bits differ
    // ------------------------------------------------------------------
    logic signed [PSUM_W-1:0] acc_q  [LANES];
    logic signed [PSUM_W-1:0] acc_d  [LANES];
    logic signed [PSUM_W-1:0] p_ext  [LANES];
    logic signed [PSUM_W-1:0] base   [LANES];
    logic signed [SUM_W-1:0]  sum    [LANES];
    logic        [PSUM_W-1:0] lim    [LANES];
    logic        [LANES-1:0]  ovf_now;

    always_comb begin : lane_sum
        ovf_now = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            p_ext[k]   = PSUM_W'(prod_q[k]);
            base[k]    = pf_q ? PSUM_W'(0) : acc_q[k];
            sum[k]     = SUM_W'(base[k]) + SUM_W'(p_ext[k]);
            ovf_now[k] = sum[k][SUM_W-1] ^ sum[k][SUM_W-2];
            if (ovf_now[k] && (SAT_EN != 0)) begin
                lim[k] = sum[k][SUM_W-1] ? SAT_MIN : SAT_MAX;
            end else begin
                lim[k] = sum[k][PSUM_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output / accumulator state update
    // ------------------------------------------------------------------
    logic [LANES-1:0] sticky_q, sticky_d;
    logic [RES_W-1:0] data_q,   data_d;
    logic [LANES-1:0] ovf_q,    ovf_d;
    logic             valid_q,  valid_d;

    always_comb begin : out_next
        acc_d    = acc_q;
        sticky_d = sticky_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        if (pv_q) begin
            if (!pm_q) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    data_d[k*PSUM_W +: PSUM_W] = p_ext[k];
                end
                ovf_d   = '0;
                valid_d = 1'b1;
            end else begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    acc_d[k]    = lim[k];
                    sticky_d[k] = (sticky_q[k] & ~pf_q) | ovf_now[k];
                end
                if (pl_q) begin
                    for (int unsigned k = 0; k < LANES; k++) begin
                        data_d[k*PSUM_W +: PSUM_W] = lim[k];
                    end
                    ovf_d   = sticky_d;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s_clk) begin : out_reg
        if (s_rst) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                acc_q[k] <= '0;
            end
            sticky_q <= '0;
            data_q   <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_systolic_mac_lanes.sv
// Bench for systolic_mac_lanes: a saturating and a wrapping instance share one stimulus stream and
// are compared every cycle against an arithmetic packet model.
module tb_systolic_mac_lanes;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PSUM_W = 20;
    localparam int unsigned PIPE   = 4;
    localparam int unsigned LAT    = PIPE + 1;
    localparam int unsigned OP_W   = LANES * DATA_W;
    localparam int unsigned RES_W  = LANES * PSUM_W;
    localparam longint PMAX = (longint'(1) << (PSUM_W - 1)) - 1;
    localparam longint PMIN = -(longint'(1) << (PSUM_W - 1));

    logic             s_clk;
    logic             s_rst;
    logic             in_valid;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             in_mode;
    logic             in_first;
    logic             in_last;
    logic [RES_W-1:0] out_data_s, out_data_w;
    logic             out_valid_s, out_valid_w;
    logic [LANES-1:0] out_ovf_s, out_ovf_w;

    systolic_mac_lanes #(
        .LANES(LANES), .DATA_W(DATA_W), .PSUM_W(PSUM_W), .PIPE(PIPE), .SAT_EN(1)
    ) u_sat (
        .s_clk(s_clk), .s_rst(s_rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .in_first(in_first), .in_last(in_last),
        .out_data(out_data_s), .out_valid(out_valid_s), .out_ovf(out_ovf_s)
    );

    systolic_mac_lanes #(
        .LANES(LANES), .DATA_W(DATA_W), .PSUM_W(PSUM_W), .PIPE(PIPE), .SAT_EN(0)
    ) u_wrap (
        .s_clk(s_clk), .s_rst(s_rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .in_first(in_first), .in_last(in_last),
        .out_data(out_data_w), .out_valid(out_valid_w), .out_ovf(out_ovf_w)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    typedef struct {
        int              due;
        bit              mode;
        bit              first;
        bit              last;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } beat_t;

    beat_t            pend[$];
    longint           acc_s [LANES];
    longint           acc_w [LANES];
    bit               st_s  [LANES];
    bit               st_w  [LANES];
    bit               ev;
    logic [RES_W-1:0] ed_s, ed_w;
    logic [LANES-1:0] eo_s, eo_w;
    int               cyc    = 0;
    int               checks = 0;
    int               errors = 0;

    function automatic longint lane_val(logic [OP_W-1:0] v, int k);
        logic signed [DATA_W-1:0] x;
        x = v[k*DATA_W +: DATA_W];
        return longint'(x);
    endfunction

    function automatic longint sat_val(longint s);
        if (s > PMAX) return PMAX;
        if (s < PMIN) return PMIN;
        return s;
    endfunction

    function automatic longint wrap_val(longint s);
        longint m, r;
        m = longint'(1) << PSUM_W;
        r = s % m;
        if (r < 0) r += m;
        if (r > PMAX) r -= m;
        return r;
    endfunction

    function automatic logic [OP_W-1:0] rep(int v);
        logic [OP_W-1:0] r;
        for (int k = 0; k < int'(LANES); k++) r[k*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    function automatic logic [OP_W-1:0] rnd_ops();
        logic [OP_W-1:0] r;
        for (int k = 0; k < int'(LANES); k++) r[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        return r;
    endfunction

    // Packet semantics applied to one beat as it reaches the output.
    task automatic apply_beat(input beat_t bt);
        longint p, s1, s2;
        bit     o1, o2;
        for (int k = 0; k < int'(LANES); k++) begin
            p = lane_val(bt.a, k) * lane_val(bt.b, k);
            if (!bt.mode) begin
                ed_s[k*PSUM_W +: PSUM_W] = PSUM_W'(p);
                ed_w[k*PSUM_W +: PSUM_W] = PSUM_W'(p);
                eo_s[k] = 1'b0;
                eo_w[k] = 1'b0;
                ev = 1'b1;
            end else begin
                s1 = (bt.first ? 0 : acc_s[k]) + p;
                s2 = (bt.first ? 0 : acc_w[k]) + p;
                o1 = (s1 > PMAX) || (s1 < PMIN);
                o2 = (s2 > PMAX) || (s2 < PMIN);
                acc_s[k] = sat_val(s1);
                acc_w[k] = wrap_val(s2);
                st_s[k] = (bt.first ? 1'b0 : st_s[k]) | o1;
                st_w[k] = (bt.first ? 1'b0 : st_w[k]) | o2;
                if (bt.last) begin
                    ed_s[k*PSUM_W +: PSUM_W] = PSUM_W'(acc_s[k]);
                    ed_w[k*PSUM_W +: PSUM_W] = PSUM_W'(acc_w[k]);
                    eo_s[k] = st_s[k];
                    eo_w[k] = st_w[k];
                    ev = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle, advance the model to this edge, then settle past the edge.
    task automatic step(input bit rst, input bit v, input bit m, input bit f, input bit l,
                        input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        beat_t bt;
        s_rst = rst; in_valid = v; in_mode = m; in_first = f; in_last = l; in_a = a; in_b = b;
        @(posedge s_clk);
        cyc++;
        ev = 1'b0;
        if (rst) begin
            pend.delete();
            for (int k = 0; k < int'(LANES); k++) begin
                acc_s[k] = 0; acc_w[k] = 0; st_s[k] = 1'b0; st_w[k] = 1'b0;
            end
            ed_s = '0; ed_w = '0; eo_s = '0; eo_w = '0;
        end else begin
            if (pend.size() != 0 && pend[0].due == cyc) apply_beat(pend.pop_front());
            if (v) begin
                bt.due = cyc + int'(LAT); bt.mode = m; bt.first = f; bt.last = l; bt.a = a; bt.b = b;
                pend.push_back(bt);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 2)       step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            else if (i < 8)  step(1'b0, 1'b1, 1'b1, i == 2, i == 7, rnd_ops(), rnd_ops());
            else if (i < 10) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, rnd_ops(), rnd_ops());
            else if (i < 12) step(1'b0, 1'b1, 1'b1, 1'b0, i == 11, rnd_ops(), rnd_ops());
            else             step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            checks++;
            if (i >= 8 && i < 16 && out_valid_s !== 1'b0) begin
                errors++; $display("FAIL reset_inflight cyc=%0d got valid %b exp 0", cyc, out_valid_s);
            end
            checks++;
            if (out_valid_s !== ev || out_valid_w !== ev) begin
                errors++; $display("FAIL reset_valid cyc=%0d got %b/%b exp %b", cyc, out_valid_s, out_valid_w, ev);
            end
            checks++;
            if (out_data_s !== ed_s || out_data_w !== ed_w) begin
                errors++; $display("FAIL reset_data cyc=%0d got %h/%h exp %h/%h", cyc, out_data_s, out_data_w, ed_s, ed_w);
            end
            checks++;
            if (out_ovf_s !== eo_s || out_ovf_w !== eo_w) begin
                errors++; $display("FAIL reset_ovf cyc=%0d got %b/%b exp %b/%b", cyc, out_ovf_s, out_ovf_w, eo_s, eo_w);
            end
        end
    endtask

    task automatic test_product();
        logic [OP_W-1:0] a, b;
        a = rnd_ops(); b = rnd_ops();
        a[DATA_W-1:0] = DATA_W'(-3);
        b[DATA_W-1:0] = DATA_W'(7);
        for (int i = 0; i < int'(LAT) + 5; i++) begin
            if (i == 0) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, a, b);
            else        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd_ops(), rnd_ops());
            checks++;
            if (out_valid_s !== (i == int'(LAT))) begin
                errors++; $display("FAIL product_latency step=%0d got valid %b", i, out_valid_s);
            end
            checks++;
            if (i >= int'(LAT) && out_data_s[PSUM_W-1:0] !== 20'hFFFEB) begin
                errors++; $display("FAIL product_lane0 step=%0d got %h exp fffeb", i, out_data_s[PSUM_W-1:0]);
            end
            checks++;
            if (out_data_s !== ed_s || out_data_w !== ed_w || out_ovf_s !== eo_s || out_ovf_w !== eo_w) begin
                errors++; $display("FAIL product_model cyc=%0d got %h/%b exp %h/%b", cyc, out_data_s, out_ovf_s, ed_s, eo_s);
            end
        end
    endtask

    task automatic test_accumulate();
        logic [OP_W-1:0] a, b;
        for (int i = 0; i < 4 + int'(LAT) + 2; i++) begin
            a = rnd_ops(); b = rnd_ops();
            a[DATA_W-1:0] = DATA_W'(10);
            b[DATA_W-1:0] = DATA_W'(10);
            if (i < 4) step(1'b0, 1'b1, 1'b1, i == 0, i == 3, a, b);
            else       step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            checks++;
            if (out_valid_s !== (i == 3 + int'(LAT)) || out_valid_w !== ev) begin
                errors++; $display("FAIL acc_strobe step=%0d got %b/%b exp %b", i, out_valid_s, out_valid_w, ev);
            end
            if (i == 3 + int'(LAT)) begin
                checks++;
                if (out_data_s[PSUM_W-1:0] !== PSUM_W'(400) || out_ovf_s[0] !== 1'b0) begin
                    errors++; $display("FAIL acc_sum got %0d ovf %b exp 400 ovf 0", out_data_s[PSUM_W-1:0], out_ovf_s[0]);
                end
            end
            checks++;
            if (out_data_s !== ed_s || out_data_w !== ed_w || out_ovf_s !== eo_s || out_ovf_w !== eo_w) begin
                errors++; $display("FAIL acc_model cyc=%0d got %h/%h exp %h/%h", cyc, out_data_s, out_data_w, ed_s, ed_w);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 41 + int'(LAT) + 2; i++) begin
            if (i < 40)       step(1'b0, 1'b1, 1'b1, i == 0, i == 39, rep(127), rep(127));
            else if (i == 40) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, rep(1), rep(1));
            else              step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            if (i == 39 + int'(LAT)) begin
                checks++;
                if (out_data_s[PSUM_W-1:0] !== 20'h7FFFF || out_ovf_s !== 4'hF) begin
                    errors++; $display("FAIL sat_clamp got %h ovf %b exp 7ffff ovf 1111", out_data_s[PSUM_W-1:0], out_ovf_s);
                end
                checks++;
                if (out_data_w[PSUM_W-1:0] !== 20'h9D828 || out_ovf_w !== 4'hF) begin
                    errors++; $display("FAIL wrap_value got %h ovf %b exp 9d828 ovf 1111", out_data_w[PSUM_W-1:0], out_ovf_w);
                end
            end
            if (i == 40 + int'(LAT)) begin
                checks++;
                if (out_valid_s !== 1'b1 || out_ovf_s !== 4'h0 || out_ovf_w !== 4'h0) begin
                    errors++; $display("FAIL ovf_clear got valid %b ovf %b/%b exp 1 0000", out_valid_s, out_ovf_s, out_ovf_w);
                end
            end
            checks++;
            if (out_valid_s !== ev || out_data_s !== ed_s || out_data_w !== ed_w || out_ovf_s !== eo_s || out_ovf_w !== eo_w) begin
                errors++; $display("FAIL sat_model cyc=%0d got %b %h/%h exp %b %h/%h", cyc, out_valid_s, out_data_s, out_data_w, ev, ed_s, ed_w);
            end
        end
    endtask

    task automatic test_mixed();
        for (int i = 0; i < 4 + int'(LAT) + 2; i++) begin
            case (i)
                0:       step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, rep(-128), rep(-128));
                1:       step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, rep(3), rep(4));
                2:       step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rep(5), rep(6));
                3:       step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, rep(2), rep(2));
                default: step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            endcase
            checks++;
            if (i == int'(LAT) && out_data_s[PSUM_W-1:0] !== PSUM_W'(16384)) begin
                errors++; $display("FAIL mixed_single got %0d exp 16384", out_data_s[PSUM_W-1:0]);
            end
            checks++;
            if (i == 2 + int'(LAT) && out_data_s[PSUM_W-1:0] !== PSUM_W'(30)) begin
                errors++; $display("FAIL mixed_product got %0d exp 30", out_data_s[PSUM_W-1:0]);
            end
            checks++;
            if (i == 3 + int'(LAT) && out_data_s[PSUM_W-1:0] !== PSUM_W'(16)) begin
                errors++; $display("FAIL mixed_packet got %0d exp 16", out_data_s[PSUM_W-1:0]);
            end
            checks++;
            if (out_valid_s !== ev || out_valid_w !== ev || out_data_s !== ed_s || out_data_w !== ed_w
                || out_ovf_s !== eo_s || out_ovf_w !== eo_w) begin
                errors++; $display("FAIL mixed_model cyc=%0d got %b %h exp %b %h", cyc, out_valid_s, out_data_s, ev, ed_s);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit r;
        for (int i = 0; i < 400; i++) begin
            r = (i < 380) && ($urandom_range(0, 99) == 0);
            if (i < 380)
                step(r, $urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, rnd_ops(), rnd_ops());
            else
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            checks++;
            if (out_valid_s !== ev || out_valid_w !== ev) begin
                errors++; $display("FAIL b2b_valid cyc=%0d got %b/%b exp %b", cyc, out_valid_s, out_valid_w, ev);
            end
            checks++;
            if (out_data_s !== ed_s || out_data_w !== ed_w) begin
                errors++; $display("FAIL b2b_data cyc=%0d got %h/%h exp %h/%h", cyc, out_data_s, out_data_w, ed_s, ed_w);
            end
            checks++;
            if (out_ovf_s !== eo_s || out_ovf_w !== eo_w) begin
                errors++; $display("FAIL b2b_ovf cyc=%0d got %b/%b exp %b/%b", cyc, out_ovf_s, out_ovf_w, eo_s, eo_w);
            end
        end
    endtask

    initial begin
        s_rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0;
        ev = 1'b0; ed_s = '0; ed_w = '0; eo_s = '0; eo_w = '0;
        test_reset();
        test_product();
        test_accumulate();
        test_saturation();
        test_mixed();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
